// File: rtl/framebuffer_pkg.sv
// Shared framebuffer definitions: AXI constants, pixel-position/tag widths, invalid tag.
// No logic, no latency.
// No flow control.
package framebuffer_pkg;

  localparam logic [1:0]  BURST_INCR      = 2'b01;
  localparam logic [7:0]  ARLEN_SINGLE    = 8'd0;
  // Wide all-ones value; users slice it down to their own tag width.
  localparam logic [63:0] TAG_INVALID_ALL = '1;

  // Bits of pixel index that select a pixel within one memory word.
  function automatic int pos_width(input int data_width, input int pixel_width);
    return $clog2(data_width / pixel_width);
  endfunction

  // Remaining upper pixel-index bits identify the memory word (line).
  function automatic int tag_width(input int addr_width, input int data_width,
                                   input int pixel_width);
    return addr_width - pos_width(data_width, pixel_width);
  endfunction

endpackage

// File: rtl/fetch_credit_counter.sv
// Outstanding read counter: +1 per AR handshake, -1 per consumed R beat; flags issue credit.
// Count updates one cycle after the handshakes; can_issue is combinational.
// A pending (not yet handshaken) AR already holds a credit so the limit is never exceeded.
module fetch_credit_counter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             pending,
  output logic [CNT_W-1:0] count,
  output logic             can_issue
);

  logic [CNT_W:0] committed;

  assign committed = {1'b0, count} + {{CNT_W{1'b0}}, pending};
  // A beat retiring this cycle always frees a credit for a new miss.
  assign can_issue = (committed < (CNT_W + 1)'(MAX_OUTSTANDING)) || dec;

  // Counter: simultaneous inc and dec cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc) begin
      count <= count - CNT_W'(1);
    end
  end

  // An R beat can only retire a read that was actually issued.
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    (dec && !inc) |-> (count != '0));

endmodule

// File: rtl/framebuffer_fetch_requester.sv
// Issues one AR per new memory word in a pixel-address stream and forwards every address to the serializer.
// Accept -> m_fetch_tvalid / arvalid one cycle later; 1 address/cycle on hits and on credited misses.
// Stalls input on a busy fetch slot, or on a miss with a busy AR slot or no credit. Optional stats: FRAMEBUFFER_FETCH_REQUESTER_STATS_EN.
module framebuffer_fetch_requester
  import framebuffer_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 8,
  parameter int PIXEL_WIDTH     = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic                  s_addr_tvalid,
  output logic                  s_addr_tready,
  input  logic [ADDR_WIDTH-1:0] s_addr_taddr,
  input  logic                  s_addr_tlast,
  output logic                  m_fetch_tvalid,
  input  logic                  m_fetch_tready,
  output logic [ADDR_WIDTH-1:0] m_fetch_taddr,
  output logic                  m_fetch_tlast,
`ifdef FRAMEBUFFER_FETCH_REQUESTER_STATS_EN
  output logic [31:0]           stat_requests,
  output logic [31:0]           stat_misses,
`endif
  output logic [ID_WIDTH-1:0]   m_mem_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_mem_axi_araddr,
  output logic [7:0]            m_mem_axi_arlen,
  output logic [2:0]            m_mem_axi_arsize,
  output logic [1:0]            m_mem_axi_arburst,
  output logic                  m_mem_axi_arvalid,
  input  logic                  m_mem_axi_arready,
  input  logic                  mon_rvalid,
  input  logic                  mon_rready
);

  localparam int POS_W   = pos_width(DATA_WIDTH, PIXEL_WIDTH);
  localparam int TAG_W   = tag_width(ADDR_WIDTH, DATA_WIDTH, PIXEL_WIDTH);
  localparam int BYTE_SH = $clog2(DATA_WIDTH / 8);
  localparam int CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [TAG_W-1:0] TAG_INV = TAG_INVALID_ALL[TAG_W-1:0];

  typedef enum logic {RUN, STALL} state_t;

  state_t           state, state_nxt;
  logic [TAG_W-1:0] tag, last_tag;
  logic [CNT_W-1:0] outstanding;
  logic             miss, slot_free, ar_free, can_issue, miss_ok, accept;
  logic             ar_fire, r_fire;

  assign tag       = s_addr_taddr[ADDR_WIDTH-1:POS_W];
  // Same compare as the serializer, so an all-ones tag hits the reset value.
  assign miss      = (tag != last_tag);
  assign slot_free = !m_fetch_tvalid || m_fetch_tready;
  assign ar_free   = !m_mem_axi_arvalid || m_mem_axi_arready;
  assign miss_ok   = ar_free && can_issue;
  assign accept    = s_addr_tvalid && s_addr_tready;
  assign ar_fire   = m_mem_axi_arvalid && m_mem_axi_arready;
  assign r_fire    = mon_rvalid && mon_rready;

  assign m_mem_axi_arid    = '0;
  assign m_mem_axi_arlen   = ARLEN_SINGLE;
  assign m_mem_axi_arsize  = 3'(BYTE_SH);
  assign m_mem_axi_arburst = BURST_INCR;

  fetch_credit_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CNT_W          (CNT_W)
  ) u_credit (
    .clk      (aclk),
    .rst      (reset),
    .inc      (ar_fire),
    .dec      (r_fire),
    .pending  (m_mem_axi_arvalid),
    .count    (outstanding),
    .can_issue(can_issue)
  );

  // State register: tracks whether a miss is waiting on credit or the AR slot.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Accept decision and stall tracking; tready never looks at tvalid.
  always_comb begin
    state_nxt     = state;
    s_addr_tready = 1'b0;
    if (!reset) s_addr_tready = slot_free && (!miss || miss_ok);
    case (state)
      RUN:     if (s_addr_tvalid && miss && !miss_ok) state_nxt = STALL;
      STALL:   if (!s_addr_tvalid || !miss || miss_ok) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Forward slot, AR slot and line tag; tlast invalidates the tag for the next frame.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      m_fetch_tvalid    <= 1'b0;
      m_fetch_taddr     <= '0;
      m_fetch_tlast     <= 1'b0;
      m_mem_axi_arvalid <= 1'b0;
      m_mem_axi_araddr  <= '0;
      last_tag          <= TAG_INV;
    end else begin
      if (accept) begin
        m_fetch_tvalid <= 1'b1;
        m_fetch_taddr  <= s_addr_taddr;
        m_fetch_tlast  <= s_addr_tlast;
      end else if (m_fetch_tready) begin
        m_fetch_tvalid <= 1'b0;
      end
      if (accept && miss) begin
        m_mem_axi_arvalid <= 1'b1;
        m_mem_axi_araddr  <= cfg_base_addr + (ADDR_WIDTH'(tag) << BYTE_SH);
      end else if (m_mem_axi_arready) begin
        m_mem_axi_arvalid <= 1'b0;
      end
      if (accept) begin
        if (s_addr_tlast) last_tag <= TAG_INV;
        else if (miss)    last_tag <= tag;
      end
    end
  end

`ifdef FRAMEBUFFER_FETCH_REQUESTER_STATS_EN
  // Free-running statistics, wrapping at 2^32.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      stat_requests <= '0;
      stat_misses   <= '0;
    end else if (accept) begin
      stat_requests <= stat_requests + 32'd1;
      if (miss) stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_framebuffer_fetch_requester.sv
// Directed bench for framebuffer_fetch_requester: hand-computed AR addresses, fetch order and stall behaviour.
// Handshakes are logged on the falling edge; inputs change 1 time unit after the rising edge.
// Bounded waits everywhere; a timed-out wait counts as a failed comparison.
module tb_framebuffer_fetch_requester;

  logic        aclk = 1'b0;
  logic        reset;
  logic [31:0] cfg_base_addr;
  logic        s_addr_tvalid, s_addr_tready, s_addr_tlast;
  logic [31:0] s_addr_taddr;
  logic        m_fetch_tvalid, m_fetch_tready, m_fetch_tlast;
  logic [31:0] m_fetch_taddr;
  logic [7:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic        mon_rvalid, mon_rready;
`ifdef FRAMEBUFFER_FETCH_REQUESTER_STATS_EN
  logic [31:0] stat_requests, stat_misses;
`endif

  int tests  = 0;
  int errors = 0;

  logic [31:0] ar_q[$];
  logic [31:0] fa_q[$];
  logic        fl_q[$];

  always #5 aclk = ~aclk;

  framebuffer_fetch_requester #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(8), .PIXEL_WIDTH(16), .MAX_OUTSTANDING(4)
  ) dut (
    .aclk             (aclk),
    .reset            (reset),
    .cfg_base_addr    (cfg_base_addr),
    .s_addr_tvalid    (s_addr_tvalid),
    .s_addr_tready    (s_addr_tready),
    .s_addr_taddr     (s_addr_taddr),
    .s_addr_tlast     (s_addr_tlast),
    .m_fetch_tvalid   (m_fetch_tvalid),
    .m_fetch_tready   (m_fetch_tready),
    .m_fetch_taddr    (m_fetch_taddr),
    .m_fetch_tlast    (m_fetch_tlast),
`ifdef FRAMEBUFFER_FETCH_REQUESTER_STATS_EN
    .stat_requests    (stat_requests),
    .stat_misses      (stat_misses),
`endif
    .m_mem_axi_arid   (arid),
    .m_mem_axi_araddr (araddr),
    .m_mem_axi_arlen  (arlen),
    .m_mem_axi_arsize (arsize),
    .m_mem_axi_arburst(arburst),
    .m_mem_axi_arvalid(arvalid),
    .m_mem_axi_arready(arready),
    .mon_rvalid       (mon_rvalid),
    .mon_rready       (mon_rready)
  );

  // Log handshakes that will complete at the next rising edge.
  always @(negedge aclk) begin
    if (!reset) begin
      if (arvalid && arready) ar_q.push_back(araddr);
      if (m_fetch_tvalid && m_fetch_tready) begin
        fa_q.push_back(m_fetch_taddr);
        fl_q.push_back(m_fetch_tlast);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Present one address until accepted (bounded), then drop tvalid.
  task automatic send(input logic [31:0] a, input logic l);
    int n;
    n = 0;
    s_addr_tvalid = 1'b1;
    s_addr_taddr  = a;
    s_addr_tlast  = l;
    @(negedge aclk);
    while (!s_addr_tready && n < 50) begin
      n++;
      @(negedge aclk);
    end
    chk("send_accept", 32'(s_addr_tready), 32'd1);
    @(posedge aclk);
    #1;
    s_addr_tvalid = 1'b0;
    s_addr_tlast  = 1'b0;
  endtask

  // Retire n R beats, one per cycle.
  task automatic drain(input int n);
    mon_rvalid = 1'b1;
    mon_rready = 1'b1;
    repeat (n) @(posedge aclk);
    #1;
    mon_rvalid = 1'b0;
    mon_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, f0;
    reset = 1'b1;
    cfg_base_addr  = 32'h1000;
    s_addr_tvalid  = 1'b0;
    s_addr_taddr   = 32'd0;
    s_addr_tlast   = 1'b0;
    m_fetch_tready = 1'b1;
    arready        = 1'b1;
    mon_rvalid     = 1'b0;
    mon_rready     = 1'b0;
    idle(3);

    // Reset state and constant AR fields.
    chk("rst_tready",   32'(s_addr_tready), 0);
    chk("rst_fvalid",   32'(m_fetch_tvalid), 0);
    chk("rst_arvalid",  32'(arvalid), 0);
    chk("rst_araddr",   araddr, 0);
    chk("rst_taddr",    m_fetch_taddr, 0);
    chk("rst_cnt",      32'(dut.u_credit.count), 0);
    chk("arsize",       32'(arsize), 2);
    chk("arburst",      32'(arburst), 1);
    chk("arlen",        32'(arlen), 0);
    chk("arid",         32'(arid), 0);
    reset = 1'b0;
    idle(1);

    // Pixels 0..3: tags 0,0,1,1 -> lines at 0x1000 and 0x1004.
    a0 = ar_q.size(); f0 = fa_q.size();
    send(32'd0, 1'b0); send(32'd1, 1'b0); send(32'd2, 1'b0); send(32'd3, 1'b1);
    idle(3);
    chk("t1_ar_cnt", 32'(ar_q.size() - a0), 2);
    chk("t1_ar0",    ar_q[a0],     32'h1000);
    chk("t1_ar1",    ar_q[a0 + 1], 32'h1004);
    chk("t1_f_cnt",  32'(fa_q.size() - f0), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_faddr", fa_q[f0 + i], 32'(i));
      chk("t1_flast", 32'(fl_q[f0 + i]), (i == 3) ? 32'd1 : 32'd0);
    end
    drain(2);
    chk("t1_cnt0", 32'(dut.u_credit.count), 0);

    // 5, 5+tlast, 5: first misses (tag still invalid after the previous tlast), second hits,
    // third misses again because tlast invalidated the tag -> two ARs to 0x1008.
    a0 = ar_q.size(); f0 = fa_q.size();
    send(32'd5, 1'b0); send(32'd5, 1'b1); send(32'd5, 1'b0);
    idle(3);
    chk("t2_ar_cnt", 32'(ar_q.size() - a0), 2);
    chk("t2_ar0",    ar_q[a0],     32'h1008);
    chk("t2_ar1",    ar_q[a0 + 1], 32'h1008);
    chk("t2_f_cnt",  32'(fa_q.size() - f0), 3);
    chk("t2_flast1", 32'(fl_q[f0 + 1]), 1);
    drain(2);

    // Credit limit 4: misses 0,2,4,6 go out, 8 stalls until one R beat retires.
    a0 = ar_q.size(); f0 = fa_q.size();
    send(32'd0, 1'b0); send(32'd2, 1'b0); send(32'd4, 1'b0); send(32'd6, 1'b0);
    s_addr_tvalid = 1'b1; s_addr_taddr = 32'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("t3_stall", 32'(s_addr_tready), 0);
    end
    @(posedge aclk); #1;
    chk("t3_cnt_full", 32'(dut.u_credit.count), 4);
    mon_rvalid = 1'b1; mon_rready = 1'b1;
    @(negedge aclk);
    chk("t3_release", 32'(s_addr_tready), 1);
    @(posedge aclk); #1;
    mon_rvalid = 1'b0; mon_rready = 1'b0; s_addr_tvalid = 1'b0;
    idle(3);
    chk("t3_ar_cnt", 32'(ar_q.size() - a0), 5);
    chk("t3_ar4",    ar_q[a0 + 4], 32'h1010);
    chk("t3_f_last", fa_q[fa_q.size() - 1], 32'd8);
    chk("t3_cnt",    32'(dut.u_credit.count), 4);
    drain(4);

    // Fetch backpressure on hits (tag 4): beat 9 held, 8 waits, no AR; then no bubble.
    a0 = ar_q.size(); f0 = fa_q.size();
    m_fetch_tready = 1'b0;
    send(32'd9, 1'b0);
    s_addr_tvalid = 1'b1; s_addr_taddr = 32'd8;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("t4_taddr_hold", m_fetch_taddr, 32'd9);
      chk("t4_tready",     32'(s_addr_tready), 0);
    end
    @(posedge aclk); #1;
    m_fetch_tready = 1'b1;
    @(negedge aclk);
    chk("t4_reload_rdy", 32'(s_addr_tready), 1);
    @(posedge aclk); #1;
    s_addr_tvalid = 1'b0;
    @(negedge aclk);
    chk("t4_no_bubble_v", 32'(m_fetch_tvalid), 1);
    chk("t4_no_bubble_a", m_fetch_taddr, 32'd8);
    idle(2);
    chk("t4_f_cnt",  32'(fa_q.size() - f0), 2);
    chk("t4_ar_cnt", 32'(ar_q.size() - a0), 0);

    // AR slot blocked: miss 20 (0x1028) waits, hit 21 still flows, miss 22 waits for arready.
    a0 = ar_q.size();
    arready = 1'b0;
    send(32'd20, 1'b0);
    send(32'd21, 1'b0);
    s_addr_tvalid = 1'b1; s_addr_taddr = 32'd22;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("t5_araddr_hold", araddr, 32'h1028);
      chk("t5_tready",      32'(s_addr_tready), 0);
    end
    @(posedge aclk); #1;
    arready = 1'b1;
    @(negedge aclk);
    chk("t5_release", 32'(s_addr_tready), 1);
    @(posedge aclk); #1;
    s_addr_tvalid = 1'b0;
    idle(3);
    chk("t5_ar_cnt", 32'(ar_q.size() - a0), 2);
    chk("t5_ar0",    ar_q[a0],     32'h1028);
    chk("t5_ar1",    ar_q[a0 + 1], 32'h102C);
    chk("t5_cnt",    32'(dut.u_credit.count), 2);

    // Reset with three outstanding and an AR pending (miss 40 -> 0x1050).
    send(32'd30, 1'b0);
    idle(2);
    chk("t6_cnt3", 32'(dut.u_credit.count), 3);
    arready = 1'b0;
    send(32'd40, 1'b0);
    idle(2);
    chk("t6_arvalid_pre", 32'(arvalid), 1);
    @(negedge aclk); #2;
    reset = 1'b1;
    #1;
    chk("t6_arvalid", 32'(arvalid), 0);
    chk("t6_araddr",  araddr, 0);
    chk("t6_fvalid",  32'(m_fetch_tvalid), 0);
    chk("t6_taddr",   m_fetch_taddr, 0);
    chk("t6_tready",  32'(s_addr_tready), 0);
    chk("t6_cnt",     32'(dut.u_credit.count), 0);
    @(posedge aclk); #1;
    reset = 1'b0;
    arready = 1'b1;
    a0 = ar_q.size();
    send(32'd40, 1'b0);
    idle(2);
    chk("t6_post_ar_cnt", 32'(ar_q.size() - a0), 1);
    chk("t6_post_ar",     ar_q[a0], 32'h1050);
    drain(1);
    chk("t6_cnt_end", 32'(dut.u_credit.count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
